// File: rtl/ap_drv_pkg.sv
// rtl/ap_drv_pkg.sv - shared types and defaults for the ap_ctrl_hs initiator
// Contents: ap_drv_state_t (IDLE/RUN/DRAIN/FINISH), AP_DRV_CNT_W_DEF (default counter width).
package ap_drv_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FINISH
    } ap_drv_state_t;

    localparam int AP_DRV_CNT_W_DEF = 32;

endpackage

// File: rtl/ap_drv_stat.sv
// rtl/ap_drv_stat.sv - saturating cycle counter with enable and synchronous clear
// Ports: clk, rst_n (async, active-low), en (count this cycle), clr (zero on next edge),
//        count (current value, sticks at all-ones).
// Only elaborated when AP_DRV_STAT_LAT_EN is defined; the driver has no other user of it.
`ifdef AP_DRV_STAT_LAT_EN
module ap_drv_stat #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/ap_ctrl_hs_driver.sv
// rtl/ap_ctrl_hs_driver.sv - initiator for the HLS ap_ctrl_hs block-level handshake
// Launches num_txn transactions into one kernel, drains completions, then holds finish.
// Ports: ap_clk, ap_rst_n (async, active-low); go, num_txn (run request, latched on accept);
//        hold_continue (forces dut_ap_continue low); dut_ap_start/ready/done/continue (kernel side);
//        started_cnt, done_cnt (accepted starts / completions); busy (RUN|DRAIN); finish (FINISH);
//        proto_err (sticky completion-without-transaction); total_cycles (run length).
// Build option: AP_DRV_STAT_LAT_EN enables the total_cycles counter; otherwise it reads 0.
module ap_ctrl_hs_driver
    import ap_drv_pkg::*;
#(
    parameter int CNT_W = AP_DRV_CNT_W_DEF
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             go,
    input  logic [CNT_W-1:0] num_txn,
    input  logic             hold_continue,
    output logic             dut_ap_start,
    input  logic             dut_ap_ready,
    input  logic             dut_ap_done,
    output logic             dut_ap_continue,
    output logic [CNT_W-1:0] started_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic             busy,
    output logic             finish,
    output logic             proto_err,
    output logic [CNT_W-1:0] total_cycles
);

    ap_drv_state_t    state;
    logic [CNT_W-1:0] num_lat;
    logic             go_ok;
    logic             start_acc;
    logic             done_acc;
    logic [CNT_W-1:0] started_nxt;
    logic [CNT_W-1:0] in_flight;

    assign busy            = (state == S_RUN) || (state == S_DRAIN);
    assign finish          = (state == S_FINISH);
    assign dut_ap_continue = busy & ~hold_continue;

    assign go_ok     = go && ((state == S_IDLE) || (state == S_FINISH));
    // dut_ap_start is only ever high in RUN, so start_acc implies RUN.
    assign start_acc = dut_ap_start & dut_ap_ready;
    assign done_acc  = dut_ap_done & dut_ap_continue;

    // A start accepted this cycle is already in flight for a done arriving in the same cycle.
    assign started_nxt = started_cnt + {{(CNT_W-1){1'b0}}, start_acc};
    assign in_flight   = started_nxt - done_cnt;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state        <= S_IDLE;
            dut_ap_start <= 1'b0;
            num_lat      <= '0;
            started_cnt  <= '0;
            done_cnt     <= '0;
            proto_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_FINISH: begin
                    if (go_ok) begin
                        num_lat     <= num_txn;
                        started_cnt <= '0;
                        done_cnt    <= '0;
                        proto_err   <= 1'b0;
                        if (num_txn == '0) begin
                            state <= S_FINISH;
                        end else begin
                            state        <= S_RUN;
                            dut_ap_start <= 1'b1;
                        end
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (start_acc) begin
                        started_cnt <= started_nxt;
                        if (started_nxt == num_lat) begin
                            dut_ap_start <= 1'b0;
                            state        <= S_DRAIN;
                        end
                    end
                    if (done_acc) begin
                        if (in_flight == '0) begin
                            proto_err <= 1'b1;
                        end else begin
                            done_cnt <= done_cnt + 1'b1;
                            // Last completion wins over the DRAIN move above should both land together.
                            if ((done_cnt + 1'b1) == num_lat) begin
                                dut_ap_start <= 1'b0;
                                state        <= S_FINISH;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef AP_DRV_STAT_LAT_EN
    // busy covers exactly the cycles from the first asserted start through the last counted done.
    ap_drv_stat #(
        .CNT_W (CNT_W)
    ) u_stat (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .en    (busy),
        .clr   (go_ok),
        .count (total_cycles)
    );
`else
    assign total_cycles = '0;
`endif

endmodule
